// File: rtl/pwm_pulse_decoder_pkg.sv
// Shared definitions for the PWM pulse generator/decoder pair.
package pwm_pulse_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEAS_HIGH,
    MEAS_LOW
  } state_e;

  localparam int unsigned CLK_HZ       = 50_000_000;
  localparam int unsigned DEF_MIN_HIGH = 45_000;     // 0.9 ms
  localparam int unsigned DEF_MAX_HIGH = 105_000;    // 2.1 ms
  localparam int unsigned DEF_TIMEOUT  = 2_500_000;  // 50 ms

endpackage

// File: rtl/pwm_pulse_decoder_sync_edge_detect.sv
// Two-flop synchronizer plus delay flop with rise/fall detection for one async input.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o,
  output logic primed_o
);

  logic       meta_q;
  logic       sync_q;
  logic       dly_q;
  logic [1:0] prime_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      dly_q   <= 1'b0;
      prime_q <= 2'b00;
    end else begin
      meta_q  <= async_i;
      sync_q  <= meta_q;
      dly_q   <= sync_q;
      prime_q <= {prime_q[0], 1'b1};
    end
  end

  // primed_o goes high once sync_o reflects the real input rather than the reset zero.
  assign primed_o = prime_q[1];
  assign sync_o   = sync_q;
  assign rise_o   = sync_q & ~dly_q;
  assign fall_o   = ~sync_q & dly_q;

endmodule

// File: rtl/pwm_pulse_decoder.sv
// Measures high time and rise-to-rise period of an RC-style PWM input, qualifies
// each pulse against a legal high-time window and flags loss of signal.
module pwm_pulse_decoder
  import pwm_pulse_decoder_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MIN_HIGH = DEF_MIN_HIGH,
  parameter int unsigned MAX_HIGH = DEF_MAX_HIGH,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] high_cycles,
  output logic [WIDTH-1:0] period_cycles,
  output logic             sample_valid,
  output logic             range_err,
  output logic             signal_lost
);

  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_HIGH);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_HIGH);
  localparam logic [WIDTH-1:0] TO_W  = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  logic pwm_s, rise, fall, primed;

  sync_edge_detect u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_i  (pwm_in),
    .sync_o   (pwm_s),
    .rise_o   (rise),
    .fall_o   (fall),
    .primed_o (primed)
  );

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hcnt_q, hcnt_d, pcnt_q, pcnt_d, hlat_q, hlat_d;
  logic [WIDTH-1:0] high_q, high_d, period_q, period_d;
  logic             sv_q, sv_d, re_q, re_d, lost_q, lost_d;

  logic [WIDTH-1:0] hcnt_inc, pcnt_inc;
  logic             timeout, in_window;

  // Counters saturate at TIMEOUT so a dead input can never wrap into a fake reading.
  assign hcnt_inc  = (hcnt_q == TO_W) ? hcnt_q : hcnt_q + ONE_W;
  assign pcnt_inc  = (pcnt_q == TO_W) ? pcnt_q : pcnt_q + ONE_W;
  assign timeout   = (pcnt_q == TO_W);
  assign in_window = (hlat_q >= MIN_W) && (hlat_q <= MAX_W);

  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    pcnt_d   = pcnt_q;
    hlat_d   = hlat_q;
    high_d   = high_q;
    period_d = period_q;
    sv_d     = 1'b0;
    re_d     = 1'b0;
    lost_d   = lost_q;
    unique case (state_q)
      IDLE: begin
        hcnt_d = '0;
        pcnt_d = '0;
        if (primed && !pwm_s) state_d = ARMED;
      end
      ARMED: begin
        if (rise) begin
          state_d = MEAS_HIGH;
          hcnt_d  = ONE_W;
          pcnt_d  = ONE_W;
        end else if (timeout) begin
          lost_d = 1'b1;
          pcnt_d = '0;
        end else begin
          pcnt_d = pcnt_inc;
        end
      end
      MEAS_HIGH: begin
        if (fall) begin
          state_d = MEAS_LOW;
          hlat_d  = hcnt_q;
          pcnt_d  = pcnt_inc;
        end else if (timeout) begin
          lost_d  = 1'b1;
          state_d = IDLE;
          hcnt_d  = '0;
          pcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_inc;
          pcnt_d = pcnt_inc;
        end
      end
      MEAS_LOW: begin
        // A rise on the timeout cycle still completes the pulse.
        if (rise) begin
          if (in_window) begin
            high_d   = hlat_q;
            period_d = pcnt_q;
            sv_d     = 1'b1;
            lost_d   = 1'b0;
          end else begin
            re_d = 1'b1;
          end
          state_d = MEAS_HIGH;
          hcnt_d  = ONE_W;
          pcnt_d  = ONE_W;
        end else if (timeout) begin
          lost_d  = 1'b1;
          state_d = ARMED;
          pcnt_d  = '0;
        end else begin
          pcnt_d = pcnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      hcnt_q   <= '0;
      pcnt_q   <= '0;
      hlat_q   <= '0;
      high_q   <= '0;
      period_q <= '0;
      sv_q     <= 1'b0;
      re_q     <= 1'b0;
      lost_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      pcnt_q   <= pcnt_d;
      hlat_q   <= hlat_d;
      high_q   <= high_d;
      period_q <= period_d;
      sv_q     <= sv_d;
      re_q     <= re_d;
      lost_q   <= lost_d;
    end
  end

  assign high_cycles   = high_q;
  assign period_cycles = period_q;
  assign sample_valid  = sv_q;
  assign range_err     = re_q;
  assign signal_lost   = lost_q;

endmodule

// File: tb/tb_pwm_pulse_decoder.sv
// Randomized pulse-train bench for pwm_pulse_decoder with scaled-down timing constants.
module tb_pwm_pulse_decoder;

  localparam int W    = 32;
  localparam int MINH = 40;
  localparam int MAXH = 100;
  localparam int TO   = 2000;

  logic         clk, rst, pwm_in;
  logic [W-1:0] high_cycles, period_cycles;
  logic         sample_valid, range_err, signal_lost;

  pwm_pulse_decoder #(.WIDTH(W), .MIN_HIGH(MINH), .MAX_HIGH(MAXH), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .pwm_in        (pwm_in),
    .high_cycles   (high_cycles),
    .period_cycles (period_cycles),
    .sample_valid  (sample_valid),
    .range_err     (range_err),
    .signal_lost   (signal_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: the previous completed pulse and the outputs it implies.
  bit           have_prev = 1'b0;
  int           prev_h = 0, prev_p = 0;
  logic [W-1:0] exp_high = '0, exp_period = '0;
  bit           exp_lost = 1'b1;

  int   cyc = 0, sv_cnt = 0, re_cnt = 0, both_cnt = 0, lost_rise_cyc = 0, rise_cyc = 0;
  logic lost_prev = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sample_valid) sv_cnt <= sv_cnt + 1;
    if (range_err) re_cnt <= re_cnt + 1;
    if (sample_valid && range_err) both_cnt <= both_cnt + 1;
    if (signal_lost && !lost_prev) lost_rise_cyc <= cyc;
    lost_prev <= signal_lost;
  end

  task automatic model_reset();
    have_prev  = 1'b0;
    exp_high   = '0;
    exp_period = '0;
    exp_lost   = 1'b1;
  endtask

  // One pulse: pwm_in high for h cycles, low for p-h. The rise completes the previous pulse.
  task automatic drive_pulse(input int h, input int p);
    bit exp_sv, exp_re;
    exp_sv = have_prev && prev_h >= MINH && prev_h <= MAXH;
    exp_re = have_prev && !exp_sv;
    if (exp_sv) begin
      exp_high   = W'(prev_h);
      exp_period = W'(prev_p);
      exp_lost   = 1'b0;
    end
    for (int c = 0; c < p; c++) begin
      @(posedge clk);
      #1 pwm_in = (c < h);
      if (c == 0) rise_cyc = cyc;
      if (c == 2) begin
        @(negedge clk);
        tests++;
        if (sample_valid !== 1'b0 || range_err !== 1'b0) begin
          fails++;
          $display("FAIL early_strobe h=%0d: sv=%0b re=%0b, required 0/0", h, sample_valid, range_err);
        end
      end
      if (c == 3) begin
        @(negedge clk);
        tests++;
        if (sample_valid !== exp_sv || range_err !== exp_re || high_cycles !== exp_high ||
            period_cycles !== exp_period || signal_lost !== exp_lost) begin
          fails++;
          $display("FAIL rise_result prev_h=%0d prev_p=%0d: sv=%0b re=%0b high=%0d period=%0d lost=%0b, required sv=%0b re=%0b high=%0d period=%0d lost=%0b",
                   prev_h, prev_p, sample_valid, range_err, high_cycles, period_cycles, signal_lost,
                   exp_sv, exp_re, exp_high, exp_period, exp_lost);
        end
      end
      if (c == 4) begin
        @(negedge clk);
        tests++;
        if (sample_valid !== 1'b0 || range_err !== 1'b0) begin
          fails++;
          $display("FAIL strobe_width h=%0d: sv=%0b re=%0b, required 0/0", h, sample_valid, range_err);
        end
      end
    end
    have_prev = 1'b1;
    prev_h    = h;
    prev_p    = p;
  endtask

  task automatic test_reset();
    tests++;
    if (high_cycles !== '0 || period_cycles !== '0 || sample_valid !== 1'b0 ||
        range_err !== 1'b0 || signal_lost !== 1'b1) begin
      fails++;
      $display("FAIL reset_values: high=%0d period=%0d sv=%0b re=%0b lost=%0b, required 0 0 0 0 1",
               high_cycles, period_cycles, sample_valid, range_err, signal_lost);
    end
  endtask

  task automatic test_range_err();
    for (int i = 0; i < 4; i++) drive_pulse(10, 300);
  endtask

  task automatic test_lock();
    for (int i = 0; i < 3; i++) drive_pulse(75, 400);
  endtask

  task automatic test_boundaries();
    int hs[5];
    hs = '{MINH - 1, MINH, MAXH, MAXH + 1, 70};
    foreach (hs[i]) drive_pulse(hs[i], 250);
    drive_pulse(70, 250);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      int h;
      h = int'($urandom_range(20, 130));
      drive_pulse(h, h + int'($urandom_range(10, 300)));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) drive_pulse(45, 55);
  endtask

  task automatic test_timeout();
    int lr0;
    drive_pulse(75, 400);
    drive_pulse(75, 80);
    lr0 = lost_rise_cyc;
    for (int k = 0; k < 3 * TO && lost_rise_cyc == lr0; k++) @(posedge clk);
    #1;
    tests++;
    if (lost_rise_cyc - rise_cyc !== 3 + TO) begin
      fails++;
      $display("FAIL timeout_latency: lost after %0d cycles from rise, required %0d",
               lost_rise_cyc - rise_cyc, 3 + TO);
    end
    repeat (500) @(posedge clk);
    #1;
    tests++;
    if (signal_lost !== 1'b1 || high_cycles !== exp_high || period_cycles !== exp_period) begin
      fails++;
      $display("FAIL timeout_hold: lost=%0b high=%0d period=%0d, required 1 %0d %0d",
               signal_lost, high_cycles, period_cycles, exp_high, exp_period);
    end
    have_prev = 1'b0;
    exp_lost  = 1'b1;
    test_lock();
  endtask

  task automatic test_stuck_high();
    int cnt0;
    drive_pulse(75, 400);
    drive_pulse(TO + 300, TO + 320);
    tests++;
    if (lost_rise_cyc - rise_cyc !== 3 + TO || signal_lost !== 1'b1) begin
      fails++;
      $display("FAIL stuck_high_lost: lost=%0b after %0d cycles, required 1 after %0d",
               signal_lost, lost_rise_cyc - rise_cyc, 3 + TO);
    end
    cnt0      = sv_cnt + re_cnt;
    have_prev = 1'b0;
    exp_lost  = 1'b1;
    drive_pulse(80, 350);
    tests++;
    if (sv_cnt + re_cnt !== cnt0) begin
      fails++;
      $display("FAIL stuck_high_strobe: %0d strobes after release, required 0", sv_cnt + re_cnt - cnt0);
    end
    drive_pulse(80, 350);
    drive_pulse(80, 350);
  endtask

  task automatic test_partial_at_reset();
    int cnt0;
    @(posedge clk);
    #1 rst = 1'b1;
    pwm_in = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1 pwm_in = 1'b0;
    cnt0 = sv_cnt + re_cnt;
    repeat (40) @(posedge clk);
    #1;
    tests++;
    if (sv_cnt + re_cnt !== cnt0) begin
      fails++;
      $display("FAIL partial_pulse: %0d strobes from partial pulse, required 0", sv_cnt + re_cnt - cnt0);
    end
    drive_pulse(70, 300);
    drive_pulse(70, 300);
    drive_pulse(70, 300);
  endtask

  task automatic test_mid_reset();
    drive_pulse(70, 300);
    drive_pulse(70, 300);
    drive_pulse(70, 150);
    #3 rst = 1'b1;
    #1;
    tests++;
    if (high_cycles !== '0 || period_cycles !== '0 || sample_valid !== 1'b0 ||
        range_err !== 1'b0 || signal_lost !== 1'b1) begin
      fails++;
      $display("FAIL async_reset: high=%0d period=%0d sv=%0b re=%0b lost=%0b, required 0 0 0 0 1",
               high_cycles, period_cycles, sample_valid, range_err, signal_lost);
    end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    drive_pulse(80, 320);
    drive_pulse(80, 320);
    drive_pulse(80, 320);
  endtask

  initial begin
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    repeat (5) @(posedge clk);
    test_range_err();
    test_lock();
    test_boundaries();
    test_random();
    test_back_to_back();
    test_timeout();
    test_stuck_high();
    test_partial_at_reset();
    test_mid_reset();
    tests++;
    if (both_cnt !== 0) begin
      fails++;
      $display("FAIL exclusive_strobes: %0d cycles with sv and re both high, required 0", both_cnt);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pwm_pulse_decoder.md
Name: pwm_pulse_decoder

Overview:
- Receive-side counterpart of the drone's PWM pulse generator.
- Measures the high time and period of one incoming RC/servo-style PWM signal in `clk` cycles, using a 50 MHz system clock.
- Qualifies each completed pulse against a legal high-time window and flags loss of signal.
- Feeds the flight controller's setpoint and failsafe logic.

Parameters:
- WIDTH, 32: width of the measurement counters and outputs.
- MIN_HIGH, 45_000: minimum legal high time in cycles (0.9 ms).
- MAX_HIGH, 105_000: maximum legal high time in cycles (2.1 ms).
- TIMEOUT, 2_500_000: cycles without a rising edge before signal loss (50 ms).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- pwm_in  in  1  asynchronous PWM input.
- high_cycles  out  WIDTH  high time of the last qualified pulse.
- period_cycles  out  WIDTH  rise-to-rise period of the last qualified pulse.
- sample_valid  out  1  one-cycle strobe when high_cycles/period_cycles update.
- range_err  out  1  one-cycle strobe when a completed pulse is outside [MIN_HIGH, MAX_HIGH].
- signal_lost  out  1  level; 1 = no valid signal.

Behaviour:
- Reset values: high_cycles=0, period_cycles=0, sample_valid=0, range_err=0, signal_lost=1, state=IDLE. All counters and synchronizer flops = 0.
- Input path:
  - 2-flop synchronizer gives pwm_s; one more flop gives pwm_d.
  - rise = pwm_s & ~pwm_d; fall = ~pwm_s & pwm_d.
  - No glitch filter.
- Counters: hcnt and pcnt, WIDTH bits, saturating at TIMEOUT. They never wrap.
- Latency: strobes and output updates are registered on the 3rd clk edge after pwm_in rises (2 synchronizer stages + 1 state register).
- State IDLE (waiting for low, which discards a partial pulse present at reset):
  - pwm_s==0 -> ARMED, pcnt=0.
- State ARMED:
  - pcnt increments each cycle.
  - On rise -> MEAS_HIGH, hcnt=1, pcnt=1.
  - If pcnt reaches TIMEOUT: signal_lost=1, pcnt=0, stay in ARMED.
- State MEAS_HIGH:
  - hcnt and pcnt increment each cycle.
  - On fall -> MEAS_LOW, h_latch=hcnt (h_latch is internal).
  - If pcnt reaches TIMEOUT (input stuck high): signal_lost=1 -> IDLE.
- State MEAS_LOW:
  - pcnt increments each cycle.
  - On rise, if MIN_HIGH <= h_latch <= MAX_HIGH: high_cycles=h_latch, period_cycles=pcnt, sample_valid=1, signal_lost=0.
  - On rise, if h_latch is out of window: range_err=1; outputs and signal_lost unchanged.
  - In both rise cases the next pulse starts immediately: hcnt=1, pcnt=1 -> MEAS_HIGH.
  - If pcnt reaches TIMEOUT: signal_lost=1 -> ARMED, pcnt=0.
- Count semantics:
  - An N-cycle high level on pwm_s yields h_latch=N.
  - Rises M cycles apart yield period_cycles=M.
- Simultaneous events:
  - A rise in the same cycle pcnt reaches TIMEOUT: the rise wins (sample processed, no loss).
  - sample_valid and range_err are never both 1.
- After timeout, high_cycles/period_cycles hold their last qualified values. Consumers gate on signal_lost.
- Reset mid-measurement: immediate return to reset values. The in-progress pulse is discarded; re-acquisition goes through IDLE.

Decomposition:
- Shared package: state enum {IDLE, ARMED, MEAS_HIGH, MEAS_LOW}, CLK_HZ=50_000_000, and default MIN_HIGH/MAX_HIGH/TIMEOUT constants, shared with the generator side.
- Sub-module: sync_edge_detect (2-flop synchronizer + delay flop, outputs pwm_s/rise/fall), reusable for other async inputs.
- Estimated size: 150–250 lines of RTL.

Test Plan:
- Stimulus: 75_000-cycle high pulses, 1_000_000-cycle period. Response: on the 2nd rise, high_cycles=75_000, period_cycles=1_000_000, a one-cycle sample_valid, and signal_lost 1->0.
- Stimulus: 1_000-cycle high pulses, 1_000_000-cycle period. Response: range_err strobe on each rise, never sample_valid; outputs stay 0 and signal_lost stays 1.
- Stimulus: valid stream locked, then pwm_in held low for 3_000_000 cycles. Response: signal_lost=1 exactly 2_500_000 cycles after the last rise; high_cycles/period_cycles keep 75_000/1_000_000.
- Stimulus: pwm_in high through reset release, falling 10_000 cycles later, then valid pulses. Response: the partial pulse produces no strobe; the first sample_valid arrives after one full period.
- Stimulus: pwm_in stuck high 2_600_000 cycles after a rise. Response: signal_lost=1 at pcnt=2_500_000, state IDLE, no strobe until low, rise and a full period follow.
- Stimulus: rst pulsed in the middle of MEAS_LOW. Response: all outputs return to reset values within the same cycle (asynchronous); the next valid period gives correct counts.
